fetch_stage: RTL

Instruction fetch stage for the 64-bit ARM pipeline. It holds the program counter and drives the combinational instruction memory's byte address. It registers the returned 32-bit word, with its PC, into the IF/ID pipeline register for decode. It also absorbs branch redirects, hazard-unit stalls and flushes, and halts on an illegal fetch address.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/if_id_reg.sv | 37 +++
 rtl/fetch_stage.sv | 110 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: fetch FSM states, NOP encoding,
// instruction memory size default and the IF/ID register layout.
package cpu_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // AArch64 NOP, used as the bubble instruction in pipeline registers
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;

  // Instruction memory size in bytes, shared with the memory model
  localparam int unsigned IMEM_SIZE_DEFAULT = 1024;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc: 64'd0, instr: NOP_INSTR};

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register holding one if_id_t with write / hold / bubble control.
// bubble has priority over wr_en; neither asserted means hold.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   wr_en,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t data_q, data_d;

  // Select bubble, new contents, or hold
  always_comb begin
    data_d = data_q;
    if (bubble) begin
      data_d = IF_ID_BUBBLE;
    end else if (wr_en) begin
      data_d = d;
    end
  end

  // Register with asynchronous active-low reset to a bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= IF_ID_BUBBLE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, fetch address
// legality check, RUN/HALT state machine and the IF/ID pipeline register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int unsigned IMEM_SIZE = IMEM_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_id_valid,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        fault
);

  fetch_state_t state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic         fault_q, fault_d;
  logic [63:0]  next_pc;
  logic [64:0]  next_end;
  logic         illegal;
  logic         ifid_wr, ifid_bubble;
  if_id_t       ifid_d, ifid_q;

  // Next-PC candidate: redirect beats stall, otherwise sequential
  always_comb begin
    if (br_taken) begin
      next_pc = br_target;
    end else if (stall) begin
      next_pc = pc_q;
    end else begin
      next_pc = pc_q + 64'd4;
    end
  end

  // Legality of a changed PC; last byte computed in 65 bits so wrap is out of bounds
  always_comb begin
    next_end = {1'b0, next_pc} + 65'd3;
    illegal  = (next_pc != pc_q) &&
               ((next_pc[1:0] != 2'b00) || (next_end >= 65'(IMEM_SIZE)));
  end

  // FSM next state: an illegal fetch freezes the PC and halts for good
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    case (state_q)
      RUN: begin
        if (illegal) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else begin
          pc_d = next_pc;
        end
      end
      HALT: begin
        state_d = HALT;
      end
    endcase
  end

  // IF/ID control: flush/redirect bubble, stall holds, HALT bubbles every cycle
  always_comb begin
    ifid_d = '{valid: 1'b1, pc: pc_q, instr: imem_instr};
    if (state_q == RUN) begin
      ifid_bubble = flush | br_taken;
      ifid_wr     = ~stall;
    end else begin
      ifid_bubble = 1'b1;
      ifid_wr     = 1'b0;
    end
  end

  // PC, state and sticky fault registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (ifid_wr),
    .bubble  (ifid_bubble),
    .d       (ifid_d),
    .q       (ifid_q)
  );

  assign imem_addr   = pc_q;
  assign if_id_valid = ifid_q.valid;
  assign if_id_pc    = ifid_q.pc;
  assign if_id_instr = ifid_q.instr;
  assign fault       = fault_q;

endmodule
